rf_wb_ctrl: RTL and testbench

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

---
 rtl/rf_wb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rf_wb_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: register-file write-back arbiter with a long-latency result queue
// and an optional pending-write scoreboard.
//
// The pipeline write port has priority. Long-latency results (mul/div/load-miss)
// wait in a 2-entry FIFO and drain into slots the pipeline leaves free. The
// selected write is registered onto the register-file write port, one cycle later.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   pl_wren/pl_wraddr/pl_data     pipeline write-back request
//   ll_valid/ll_addr/ll_data      long-latency result offered to the queue
//   ll_ready                      queue can accept (registered count < 2)
//   ll_issue/ll_issue_addr        long-latency op issued; marks its destination pending
//   rs_addr/rt_addr/rd_addr       decode-stage register addresses
//   pend_a/pend_b/pend_d          combinational scoreboard hits for rs/rt/rd
//   data/wraddress/wren           registered register-file write port
//
// Configuration macro: RF_WB_SCOREBOARD_EN
//   defined   -> 32-bit pending scoreboard drives pend_a/pend_b/pend_d
//   undefined -> no pending storage; pend flags tied 0; ll_issue inputs ignored

module rf_wb_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        pl_wren,
    input  logic [4:0]  pl_wraddr,
    input  logic [31:0] pl_data,
    input  logic        ll_valid,
    input  logic [4:0]  ll_addr,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    input  logic        ll_issue,
    input  logic [4:0]  ll_issue_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    output logic        pend_a,
    output logic        pend_b,
    output logic        pend_d,
    output logic [31:0] data,
    output logic [4:0]  wraddress,
    output logic        wren
);

    // Long-latency FIFO storage
    logic [4:0]  addr_q [2];
    logic [31:0] data_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    // Write port registers
    logic [31:0] data_q_out, data_d_out;
    logic [4:0]  waddr_q, waddr_d;
    logic        wren_q, wren_d;

    logic        pl_slot;
    logic        push;
    logic        pop;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // ll_ready comes from the registered count only, so it never depends on
    // this cycle's pop.
    assign ll_ready  = (count_q < 2'd2);
    assign push      = ll_valid & ll_ready;
    // A write to r0 does not claim the slot, so the queue can drain there.
    assign pl_slot   = pl_wren & (pl_wraddr != 5'd0);
    // Registered count: an entry pushed this cycle cannot be popped this cycle.
    assign pop       = ~pl_slot & (count_q != 2'd0);
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wren_d     = 1'b0;
        data_d_out = data_q_out;
        waddr_d    = waddr_q;

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // data/wraddress only move on an actual write; otherwise they hold.
        if (pl_slot) begin
            wren_d     = 1'b1;
            data_d_out = pl_data;
            waddr_d    = pl_wraddr;
        end else if (pop && (head_addr != 5'd0)) begin
            wren_d     = 1'b1;
            data_d_out = head_data;
            waddr_d    = head_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            wren_q     <= 1'b0;
            data_q_out <= 32'd0;
            waddr_q    <= 5'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wren_q     <= wren_d;
            data_q_out <= data_d_out;
            waddr_q    <= waddr_d;
        end
    end

    // Entry storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= ll_addr;
            data_q[wr_ptr_q] <= ll_data;
        end
    end

    assign data      = data_q_out;
    assign wraddress = waddr_q;
    assign wren      = wren_q;

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle set wins.
        if (ll_issue && (ll_issue_addr != 5'd0)) begin
            pending_d[ll_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pend_a = pending_q[rs_addr] & (rs_addr != 5'd0);
    assign pend_b = pending_q[rt_addr] & (rt_addr != 5'd0);
    assign pend_d = pending_q[rd_addr] & (rd_addr != 5'd0);
`else
    logic unused_sb;
    assign unused_sb = ^{ll_issue, ll_issue_addr, rs_addr, rt_addr, rd_addr};

    assign pend_a = 1'b0;
    assign pend_b = 1'b0;
    assign pend_d = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked each cycle against a
// queue-based behavioural model.

module tb_rf_wb_ctrl;

`ifdef RF_WB_SCOREBOARD_EN
    localparam bit Sb = 1'b1;
`else
    localparam bit Sb = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pl_wren;
    logic [4:0]  pl_wraddr;
    logic [31:0] pl_data;
    logic        ll_valid;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic        ll_issue;
    logic [4:0]  ll_issue_addr;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        pend_a, pend_b, pend_d;
    logic [31:0] data;
    logic [4:0]  wraddress;
    logic        wren;

    rf_wb_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pl_wren      (pl_wren),
        .pl_wraddr    (pl_wraddr),
        .pl_data      (pl_data),
        .ll_valid     (ll_valid),
        .ll_addr      (ll_addr),
        .ll_data      (ll_data),
        .ll_ready     (ll_ready),
        .ll_issue     (ll_issue),
        .ll_issue_addr(ll_issue_addr),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rd_addr      (rd_addr),
        .pend_a       (pend_a),
        .pend_b       (pend_b),
        .pend_d       (pend_d),
        .data         (data),
        .wraddress    (wraddress),
        .wren         (wren)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          pending[32];
    bit          m_valid = 1'b0;
    logic        m_wren;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            foreach (pending[i]) pending[i] = 1'b0;
            m_wren  = 1'b0;
            m_addr  = 5'd0;
            m_data  = 32'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            bit   room;
            ent_t e;
            room   = (q.size() < 2);
            m_wren = 1'b0;
            if (pl_wren && pl_wraddr != 5'd0) begin
                m_wren = 1'b1;
                m_addr = pl_wraddr;
                m_data = pl_data;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                pending[e.a] = 1'b0;
                if (e.a != 5'd0) begin
                    m_wren = 1'b1;
                    m_addr = e.a;
                    m_data = e.d;
                end
            end
            if (ll_valid && room) q.push_back('{a: ll_addr, d: ll_data});
            if (Sb && ll_issue && ll_issue_addr != 5'd0) pending[ll_issue_addr] = 1'b1;
        end
    end

    function automatic logic pend_of(logic [4:0] a);
        return Sb && a != 5'd0 && pending[a];
    endfunction

    // Compare on the falling edge, away from the active edge and input changes.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("wren", {31'd0, wren}, {31'd0, m_wren});
            chk("wraddress", {27'd0, wraddress}, {27'd0, m_addr});
            chk("data", data, m_data);
            chk("ll_ready", {31'd0, ll_ready}, {31'd0, q.size() < 2});
            chk("pend_a", {31'd0, pend_a}, {31'd0, pend_of(rs_addr)});
            chk("pend_b", {31'd0, pend_b}, {31'd0, pend_of(rt_addr)});
            chk("pend_d", {31'd0, pend_d}, {31'd0, pend_of(rd_addr)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; pl_wren = 1'b0; pl_wraddr = '0; pl_data = '0;
        ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
        ll_issue = 1'b0; ll_issue_addr = '0;
        rs_addr = '0; rt_addr = '0; rd_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic pl(logic en, logic [4:0] a, logic [31:0] d);
        pl_wren = en; pl_wraddr = a; pl_data = d;
    endtask

    task automatic llv(logic v, logic [4:0] a, logic [31:0] d);
        ll_valid = v; ll_addr = a; ll_data = d;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        chk("reset_wren", {31'd0, wren}, 32'd0);
        chk("reset_data", data, 32'd0);
        chk("reset_waddr", {27'd0, wraddress}, 32'd0);
        chk("reset_ready", {31'd0, ll_ready}, 32'd1);

        // Pipeline only
        pl(1, 5'd5, 32'h1234);
        cyc();
        chk("pl_wren", {31'd0, wren}, 32'd1);
        chk("pl_waddr", {27'd0, wraddress}, 32'd5);
        chk("pl_data", data, 32'h1234);
        pl(0, 0, 0);
        cyc();
        chk("idle_wren", {31'd0, wren}, 32'd0);
        chk("idle_hold", data, 32'h1234);

        // Contention: pipeline busy 3 cycles, queued r7 drains after
        pl(1, 5'd3, 32'h33);
        llv(1, 5'd7, 32'hAA);
        cyc();
        llv(0, 0, 0);
        cyc(2);
        chk("cont_r3", {27'd0, wraddress}, 32'd3);
        pl(0, 0, 0);
        cyc();
        chk("cont_wren", {31'd0, wren}, 32'd1);
        chk("cont_waddr", {27'd0, wraddress}, 32'd7);
        chk("cont_data", data, 32'hAA);

        // Full queue, held third entry, order 1,2,3
        pl(1, 5'd4, 32'h44);
        llv(1, 5'd1, 32'h11);
        cyc();
        llv(1, 5'd2, 32'h22);
        cyc();
        chk("full_ready", {31'd0, ll_ready}, 32'd0);
        llv(1, 5'd3, 32'h33);
        cyc();
        chk("full_ready2", {31'd0, ll_ready}, 32'd0);
        pl(0, 0, 0);
        cyc();
        chk("full_first", {27'd0, wraddress}, 32'd1);
        chk("full_ready3", {31'd0, ll_ready}, 32'd1);
        cyc();
        llv(0, 0, 0);
        chk("full_second", {27'd0, wraddress}, 32'd2);
        cyc();
        chk("full_third", {27'd0, wraddress}, 32'd3);
        chk("full_third_d", data, 32'h33);

        // r0 filter lets the queue drain
        pl(1, 5'd3, 32'h0);
        llv(1, 5'd9, 32'h99);
        cyc();
        llv(0, 0, 0);
        pl(1, 5'd0, 32'hDEAD);
        cyc();
        chk("r0_wren", {31'd0, wren}, 32'd1);
        chk("r0_waddr", {27'd0, wraddress}, 32'd9);
        pl(0, 0, 0);

        // Minimum latency: push into empty queue is not popped the same cycle
        llv(1, 5'd6, 32'h66);
        cyc();
        llv(0, 0, 0);
        chk("lat_nowrite", {31'd0, wren}, 32'd0);
        cyc();
        chk("lat_write", {27'd0, wraddress}, 32'd6);

        // Scoreboard set / clear / set-wins
        ll_issue = 1; ll_issue_addr = 5'd12;
        cyc();
        ll_issue = 0;
        rs_addr = 5'd12;
        #1 chk("sb_set", {31'd0, pend_a}, {31'd0, Sb});
        pl(1, 5'd2, 32'h2);
        llv(1, 5'd12, 32'hC);
        cyc();
        llv(0, 0, 0);
        pl(0, 0, 0);
        cyc();
        chk("sb_clear", {31'd0, pend_a}, 32'd0);
        pl(1, 5'd2, 32'h2);
        llv(1, 5'd12, 32'hC);
        cyc();
        llv(0, 0, 0);
        pl(0, 0, 0);
        ll_issue = 1; ll_issue_addr = 5'd12;
        cyc();
        ll_issue = 0;
        chk("sb_setwins", {31'd0, pend_a}, {31'd0, Sb});

        // Reset with queued entries and pending bits
        pl(1, 5'd2, 32'h2);
        llv(1, 5'd20, 32'h20);
        ll_issue = 1; ll_issue_addr = 5'd21;
        cyc();
        llv(1, 5'd21, 32'h21);
        ll_issue = 0;
        cyc();
        llv(0, 0, 0);
        pl(0, 0, 0);
        do_reset();
        rs_addr = 5'd12; rt_addr = 5'd21;
        #1;
        chk("rst_wren", {31'd0, wren}, 32'd0);
        chk("rst_ready", {31'd0, ll_ready}, 32'd1);
        chk("rst_pend_a", {31'd0, pend_a}, 32'd0);
        chk("rst_pend_b", {31'd0, pend_b}, 32'd0);
        cyc(3);
        chk("rst_nodrain", {31'd0, wren}, 32'd0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(299) == 0);
            pl_wren       = ($urandom_range(99) < 45);
            pl_wraddr     = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(15));
            pl_data       = $urandom;
            ll_valid      = ($urandom_range(99) < 50);
            ll_addr       = 5'($urandom_range(15));
            ll_data       = $urandom;
            ll_issue      = ($urandom_range(99) < 30);
            ll_issue_addr = 5'($urandom_range(15));
            rs_addr       = 5'($urandom_range(15));
            rt_addr       = 5'($urandom_range(15));
            rd_addr       = 5'($urandom_range(15));
            cyc();
        end
        idle_inputs();
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
